// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types for the CPU clock controller: FSM state encoding and mode values.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN           = 3'd0,
        ST_STEP_IDLE     = 3'd1,
        ST_STEP_FIRE     = 3'd2,
        ST_STEP_WAIT_REL = 3'd3,
        ST_HALT          = 3'd4
    } cpu_state_e;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    // States from which a mode change or a live cycle-limit halt may be taken.
    function automatic logic is_mode_state(input cpu_state_e s);
        return (s == ST_RUN) || (s == ST_STEP_IDLE);
    endfunction

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Bundle of the controller's control/status signals, for benches and wrappers.
interface cpu_clock_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             clk_step;
    logic             clk_select;
    logic [CNT_W-1:0] cycle_limit;
    logic             cpu_en;
    logic             step_pulse;
    logic [CNT_W-1:0] cycle_count;
    logic             halted;

    modport master (
        output clk_step, clk_select, cycle_limit,
        input  cpu_en, step_pulse, cycle_count, halted
    );

    modport slave (
        input  clk_step, clk_select, cycle_limit,
        output cpu_en, step_pulse, cycle_count, halted
    );
endinterface

// File: rtl/cpu_clock_ctrl_debounce.sv
// Level debouncer: a new level is accepted after DEBOUNCE_CYCLES consecutive
// samples that differ from the current accepted level; rise strobes on 0->1.
module debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (din == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = din;
            cnt_d   = '0;
            rise_d  = din;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign dout = level_q;
    assign rise = rise_q;
endmodule

// File: rtl/cpu_clock_ctrl.sv
// Processor clock-enable controller: free-run / single-step modes with a
// debounced step button, saturating cycle counter and cycle-limit halt.
module cpu_clock_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_step,
    input  logic             clk_select,
    input  logic [CNT_W-1:0] cycle_limit,
    output logic             cpu_en,
    output logic             step_pulse,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted,
    output cpu_state_e       state_dbg_o
);
    logic step_meta_q, step_sync_q;
    logic sel_meta_q, sel_sync_q;
    logic db_level, db_rise;

    cpu_state_e       state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             step_pulse_q, step_pulse_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_inc;
    logic             limit_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            sel_meta_q  <= 1'b0;
            sel_sync_q  <= 1'b0;
        end else begin
            step_meta_q <= clk_step;
            step_sync_q <= step_meta_q;
            sel_meta_q  <= clk_select;
            sel_sync_q  <= sel_meta_q;
        end
    end

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (step_sync_q),
        .dout (db_level),
        .rise (db_rise)
    );

    // cpu_en_q mirrors the current state, so it marks the cycle being counted now.
    always_comb begin
        count_inc = cpu_en_q && (count_q != '1);
        count_d   = count_q + CNT_W'(count_inc);
        limit_hit = (cycle_limit != '0) && (count_d >= cycle_limit)
                    && (cpu_en_q || is_mode_state(state_q));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (limit_hit)                    state_d = ST_HALT;
                else if (sel_sync_q == MODE_STEP) state_d = ST_STEP_IDLE;
            end
            ST_STEP_IDLE: begin
                if (limit_hit)                    state_d = ST_HALT;
                else if (sel_sync_q == MODE_RUN)  state_d = ST_RUN;
                else if (db_rise)                 state_d = ST_STEP_FIRE;
            end
            ST_STEP_FIRE: begin
                if (limit_hit) state_d = ST_HALT;
                else           state_d = ST_STEP_WAIT_REL;
            end
            ST_STEP_WAIT_REL: begin
                if (!db_level) state_d = ST_STEP_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        cpu_en_d     = (state_d == ST_RUN) || (state_d == ST_STEP_FIRE);
        step_pulse_d = (state_d == ST_STEP_FIRE);
        halted_d     = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cpu_en_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            step_pulse_q <= step_pulse_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign step_pulse  = step_pulse_q;
    assign halted      = halted_q;
    assign cycle_count = count_q;
    assign state_dbg_o = state_q;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl: directed scenarios plus randomized
// button press trains scored against a run-length model of the debouncer.
module tb_cpu_clock_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int DEB   = 16;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    cpu_state_e state_dbg;

    cpu_clock_ctrl_if #(.CNT_W(CNT_W)) ctl();

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_step    (ctl.clk_step),
        .clk_select  (ctl.clk_select),
        .cycle_limit (ctl.cycle_limit),
        .cpu_en      (ctl.cpu_en),
        .step_pulse  (ctl.step_pulse),
        .cycle_count (ctl.cycle_count),
        .halted      (ctl.halted),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;
    int pulse_cnt = 0;

    // One clock: sample 1 time unit after the rising edge and tally enables/pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ctl.cpu_en === 1'b1) en_cnt++;
        if (ctl.step_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic do_reset(input logic sel, input logic [CNT_W-1:0] lim);
        ctl.clk_select  = sel;
        ctl.cycle_limit = lim;
        ctl.clk_step    = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en_cnt = 0;
        pulse_cnt = 0;
    endtask

    task automatic hold_step(input logic v, input int n);
        ctl.clk_step = v;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        ctl.clk_step = 1'b1;
        ctl.clk_select = 1'b1;
        ctl.cycle_limit = 32'd7;
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (ctl.cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_cpu_en: got %0b expected 0", ctl.cpu_en); end
        n_vec++; if (ctl.step_pulse !== 1'b0) begin n_err++; $display("FAIL reset_step_pulse: got %0b expected 0", ctl.step_pulse); end
        n_vec++; if (ctl.halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %0b expected 0", ctl.halted); end
        n_vec++; if (ctl.cycle_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", ctl.cycle_count); end
        n_vec++; if (state_dbg !== ST_RUN) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_RUN); end
    endtask

    task automatic test_run_limit();
        int  last_en;
        int  first_halt;
        bit  halt_dropped;
        last_en = -1;
        first_halt = -1;
        halt_dropped = 1'b0;
        do_reset(1'b0, 32'd50);
        for (int i = 0; i < 80; i++) begin
            if (i == 60) begin
                ctl.clk_select = 1'b1;
                ctl.clk_step = 1'b1;
            end
            tick();
            if (ctl.cpu_en) last_en = i;
            if (ctl.halted && first_halt < 0) first_halt = i;
            if (first_halt >= 0 && !ctl.halted) halt_dropped = 1'b1;
        end
        n_vec++; if (en_cnt != 50) begin n_err++; $display("FAIL limit_en_cycles: got %0d expected 50", en_cnt); end
        n_vec++; if (ctl.cycle_count !== 32'd50) begin n_err++; $display("FAIL limit_count: got %0d expected 50", ctl.cycle_count); end
        n_vec++; if (first_halt != last_en + 1) begin n_err++; $display("FAIL limit_halt_timing: got %0d expected %0d", first_halt, last_en + 1); end
        n_vec++; if (halt_dropped) begin n_err++; $display("FAIL limit_halt_sticky: got 1 expected 0"); end
        n_vec++; if (ctl.cpu_en !== 1'b0 || ctl.step_pulse !== 1'b0) begin n_err++; $display("FAIL limit_halt_quiet: got en=%0b pulse=%0b expected 0", ctl.cpu_en, ctl.step_pulse); end
        ctl.clk_step = 1'b0;
        ctl.clk_select = 1'b0;
    endtask

    task automatic test_held_step();
        int base;
        int p0;
        do_reset(1'b1, '0);
        repeat (8) tick();
        base = int'(ctl.cycle_count);
        n_vec++; if (base != en_cnt) begin n_err++; $display("FAIL held_settle_count: got %0d expected %0d", base, en_cnt); end
        p0 = pulse_cnt;
        hold_step(1'b1, 40);
        hold_step(1'b0, 40);
        n_vec++; if (pulse_cnt - p0 != 1) begin n_err++; $display("FAIL held_pulses: got %0d expected 1", pulse_cnt - p0); end
        n_vec++; if (int'(ctl.cycle_count) - base != 1) begin n_err++; $display("FAIL held_count: got %0d expected 1", int'(ctl.cycle_count) - base); end
    endtask

    task automatic test_glitch();
        int base;
        int p0;
        base = int'(ctl.cycle_count);
        p0 = pulse_cnt;
        hold_step(1'b1, 5);
        hold_step(1'b0, 30);
        n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt - p0); end
        n_vec++; if (int'(ctl.cycle_count) != base) begin n_err++; $display("FAIL glitch_count: got %0d expected %0d", ctl.cycle_count, base); end
    endtask

    task automatic test_three_presses();
        int base;
        int p0;
        base = int'(ctl.cycle_count);
        p0 = pulse_cnt;
        repeat (3) begin
            hold_step(1'b1, 30);
            hold_step(1'b0, 30);
        end
        n_vec++; if (pulse_cnt - p0 != 3) begin n_err++; $display("FAIL three_pulses: got %0d expected 3", pulse_cnt - p0); end
        n_vec++; if (int'(ctl.cycle_count) - base != 3) begin n_err++; $display("FAIL three_count: got %0d expected 3", int'(ctl.cycle_count) - base); end
    endtask

    // Segments alternate high/low, so a segment differing from the accepted
    // level is accepted exactly when it lasts at least DEB samples.
    task automatic test_random_presses();
        int  base;
        int  p0;
        int  e0;
        int  nseg;
        int  len;
        int  exp_steps;
        logic level;
        logic v;
        for (int r = 0; r < 4; r++) begin
            do_reset(1'b1, '0);
            repeat (8) tick();
            base = int'(ctl.cycle_count);
            p0 = pulse_cnt;
            e0 = en_cnt;
            nseg = int'($urandom_range(3, 8));
            level = 1'b0;
            exp_steps = 0;
            for (int s = 0; s < nseg; s++) begin
                v = (s % 2 == 0);
                len = int'($urandom_range(1, 40));
                if (v != level && len >= DEB) begin
                    level = v;
                    if (v) exp_steps++;
                end
                hold_step(v, len);
            end
            hold_step(1'b0, 40);
            n_vec++; if (pulse_cnt - p0 != exp_steps) begin n_err++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d", r, pulse_cnt - p0, exp_steps); end
            n_vec++; if (int'(ctl.cycle_count) - base != exp_steps) begin n_err++; $display("FAIL rand_count[%0d]: got %0d expected %0d", r, int'(ctl.cycle_count) - base, exp_steps); end
            n_vec++; if (en_cnt - e0 != exp_steps) begin n_err++; $display("FAIL rand_en_cycles[%0d]: got %0d expected %0d", r, en_cnt - e0, exp_steps); end
        end
    endtask

    task automatic test_mode_switch();
        int lat;
        int c0;
        lat = -1;
        do_reset(1'b0, '0);
        repeat (10) tick();
        ctl.clk_select = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!ctl.cpu_en && lat < 0) lat = i + 1;
        end
        n_vec++; if (lat < 1 || lat > 4) begin n_err++; $display("FAIL mode_drop_latency: got %0d expected 1..4", lat); end
        c0 = int'(ctl.cycle_count);
        repeat (20) tick();
        n_vec++; if (int'(ctl.cycle_count) != c0) begin n_err++; $display("FAIL mode_count_frozen: got %0d expected %0d", ctl.cycle_count, c0); end
        n_vec++; if (int'(ctl.cycle_count) != en_cnt) begin n_err++; $display("FAIL mode_count_vs_en: got %0d expected %0d", ctl.cycle_count, en_cnt); end
        ctl.clk_select = 1'b0;
        repeat (6) tick();
        n_vec++; if (ctl.cpu_en !== 1'b1) begin n_err++; $display("FAIL mode_back_to_run: got %0b expected 1", ctl.cpu_en); end
    endtask

    task automatic test_live_limit();
        int c0;
        int p0;
        do_reset(1'b0, '0);
        repeat (20) tick();
        ctl.cycle_limit = 32'd5;
        tick();
        n_vec++; if (ctl.halted !== 1'b1) begin n_err++; $display("FAIL live_run_halt: got %0b expected 1", ctl.halted); end
        n_vec++; if (int'(ctl.cycle_count) != en_cnt) begin n_err++; $display("FAIL live_run_count: got %0d expected %0d", ctl.cycle_count, en_cnt); end
        do_reset(1'b1, '0);
        repeat (8) tick();
        c0 = int'(ctl.cycle_count);
        p0 = pulse_cnt;
        ctl.cycle_limit = ctl.cycle_count;
        tick();
        n_vec++; if (ctl.halted !== 1'b1) begin n_err++; $display("FAIL live_idle_halt: got %0b expected 1", ctl.halted); end
        hold_step(1'b1, 30);
        ctl.clk_select = 1'b0;
        hold_step(1'b0, 10);
        n_vec++; if (pulse_cnt != p0 || int'(ctl.cycle_count) != c0) begin n_err++; $display("FAIL live_halt_ignores: got pulses=%0d count=%0d expected 0 and %0d", pulse_cnt - p0, ctl.cycle_count, c0); end
    endtask

    task automatic test_reset_abort();
        do_reset(1'b1, '0);
        repeat (8) tick();
        hold_step(1'b1, 25);
        n_vec++; if (state_dbg !== ST_STEP_WAIT_REL) begin n_err++; $display("FAIL abort_pre_state: got %0d expected %0d", state_dbg, ST_STEP_WAIT_REL); end
        rst = 1'b1;
        ctl.clk_select = 1'b0;
        tick();
        n_vec++; if (ctl.cpu_en !== 1'b0 || ctl.step_pulse !== 1'b0 || ctl.halted !== 1'b0 || ctl.cycle_count !== '0)
            begin n_err++; $display("FAIL abort_wait_outputs: got en=%0b pulse=%0b halt=%0b cnt=%0d expected all 0", ctl.cpu_en, ctl.step_pulse, ctl.halted, ctl.cycle_count); end
        rst = 1'b0;
        tick();
        n_vec++; if (ctl.cpu_en !== 1'b1) begin n_err++; $display("FAIL abort_wait_resume: got %0b expected 1", ctl.cpu_en); end
        ctl.clk_step = 1'b0;
        ctl.cycle_limit = 32'd3;
        repeat (10) tick();
        n_vec++; if (ctl.halted !== 1'b1) begin n_err++; $display("FAIL abort_pre_halt: got %0b expected 1", ctl.halted); end
        rst = 1'b1;
        tick();
        n_vec++; if (ctl.cpu_en !== 1'b0 || ctl.halted !== 1'b0 || ctl.cycle_count !== '0)
            begin n_err++; $display("FAIL abort_halt_outputs: got en=%0b halt=%0b cnt=%0d expected all 0", ctl.cpu_en, ctl.halted, ctl.cycle_count); end
        rst = 1'b0;
        ctl.cycle_limit = '0;
        tick();
        n_vec++; if (ctl.cpu_en !== 1'b1 || ctl.halted !== 1'b0) begin n_err++; $display("FAIL abort_halt_resume: got en=%0b halt=%0b expected 1 0", ctl.cpu_en, ctl.halted); end
    endtask

    initial begin
        ctl.clk_step = 1'b0;
        ctl.clk_select = 1'b0;
        ctl.cycle_limit = '0;
        test_reset();
        test_run_limit();
        test_held_step();
        test_glitch();
        test_three_presses();
        test_random_presses();
        test_mode_switch();
        test_live_limit();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
